// File: rtl/seq_sampler.sv
// Key sampler with per-slot step recording and one-shot / looped playback.
// Latency: note is registered, one cycle after key_vec (LIVE) or the tick (PLAY/LOOP).
// Backpressure: none; step/tick are single-cycle strobes, and a strobe that meets a mode change is dropped.
module seq_sampler #(
  parameter int KEYS  = 5,
  parameter int DEPTH = 8,
  parameter int SLOTS = 2,
  localparam int SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [KEYS-1:0] key_vec,
  input  logic [1:0]      mode,
  input  logic [SW-1:0]   slot_sel,
  input  logic            step,
  input  logic            tick,
  output logic [KEYS-1:0] note,
  output logic [LW-1:0]   len,
  output logic            full,
  output logic            done
);

  localparam logic [1:0] S_LIVE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [1:0] M_LIVE = 2'b00;
  localparam logic [1:0] M_REC  = 2'b01;
  localparam logic [1:0] M_LOOP = 2'b11;

  localparam int            AW      = LW - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [1:0]      state;
  logic [1:0]      mode_q;
  logic [SW-1:0]   cur_slot;
  logic [LW-1:0]   rd_ptr;
  logic [LW-1:0]   len_q [SLOTS];
  logic [KEYS-1:0] mem   [SLOTS][DEPTH];

  logic            mode_chg;
  logic            key_ok;
  logic            wr_en;
  logic            at_end;
  logic [LW-1:0]   cur_len;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [KEYS-1:0] rd_dat;
  logic [SW-1:0]   view_slot;

  // A mode change is any difference from last cycle's mode, so PLAY<->LOOP
  // also counts and restarts playback from step 0.
  assign mode_chg = (mode != mode_q);

  // Rest (all zero) or exactly one key held.
  assign key_ok   = ((key_vec & (key_vec - KEYS'(1))) == '0);

  assign cur_len  = len_q[cur_slot];
  assign at_end   = (rd_ptr == cur_len);

  // Single write port: the next free step of the slot being recorded.
  assign wr_addr  = cur_len[AW-1:0];
  assign wr_en    = (state == S_REC) && !mode_chg && step && key_ok && (cur_len != DEPTH_L);

  // Single read port: at the end of the sequence a loop wraps back to step 0.
  assign rd_addr  = at_end ? '0 : rd_ptr[AW-1:0];
  assign rd_dat   = mem[cur_slot][rd_addr];

  // Status follows the latched slot while recording/playing, else slot_sel.
  assign view_slot = ((state == S_REC) || (state == S_PLAY)) ? cur_slot : slot_sel;
  assign len       = len_q[view_slot];
  assign full      = (len == DEPTH_L);

  // Step storage; no reset, an empty slot is defined by its length alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cur_slot][wr_addr] <= key_vec;
    end
  end

  // Mode tracking, record/playback control and the registered note output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_LIVE;
      mode_q   <= M_LIVE;
      cur_slot <= '0;
      rd_ptr   <= '0;
      note     <= '0;
      done     <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        len_q[i] <= '0;
      end
    end else begin
      mode_q <= mode;
      done   <= 1'b0;
      if (mode == M_LIVE) begin
        state <= S_LIVE;
        note  <= key_ok ? key_vec : '0;
      end else if (mode_chg) begin
        // Entry into REC or PLAY/LOOP; any step/tick this cycle is dropped.
        cur_slot <= slot_sel;
        note     <= '0;
        if (mode == M_REC) begin
          state           <= S_REC;
          len_q[slot_sel] <= '0;
        end else begin
          state  <= S_PLAY;
          rd_ptr <= '0;
        end
      end else begin
        case (state)
          S_REC: begin
            note <= '0;
            if (wr_en) begin
              len_q[cur_slot] <= cur_len + LW'(1);
            end
          end
          S_PLAY: begin
            if (tick) begin
              if (!at_end) begin
                note   <= rd_dat;
                rd_ptr <= rd_ptr + LW'(1);
              end else if (mode == M_LOOP) begin
                // An empty slot in LOOP just keeps resting.
                if (cur_len == '0) begin
                  note <= '0;
                end else begin
                  note   <= rd_dat;
                  rd_ptr <= LW'(1);
                end
              end else begin
                note  <= '0;
                done  <= 1'b1;
                state <= S_HALT;
              end
            end
          end
          default: begin
            note <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_sampler.sv
module tb_seq_sampler;

  localparam int KEYS  = 5;
  localparam int DEPTH = 8;
  localparam int SLOTS = 2;
  localparam int SW    = 1;
  localparam int LW    = 4;

  localparam logic [1:0] LIVE = 2'd0;
  localparam logic [1:0] REC  = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;
  localparam logic [1:0] LOOP = 2'd3;

  localparam int CTX_LIVE = 0;
  localparam int CTX_REC  = 1;
  localparam int CTX_PLAY = 2;
  localparam int CTX_HALT = 3;

  logic            clk;
  logic            reset;
  logic [KEYS-1:0] key_vec;
  logic [1:0]      mode;
  logic [SW-1:0]   slot_sel;
  logic            step;
  logic            tick;
  logic [KEYS-1:0] note;
  logic [LW-1:0]   len;
  logic            full;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each slot is a queue of recorded steps; playback is
  // indexed by a count of ticks since entry.
  logic [KEYS-1:0] m_store [SLOTS][$];
  int              m_ctx;
  int              m_slot;
  int              m_k;
  logic [1:0]      m_prev;
  logic [KEYS-1:0] m_note;
  logic            m_done;

  typedef struct {
    logic [KEYS-1:0] key;
    logic [KEYS-1:0] exp;
  } live_vec_t;

  live_vec_t lv [6];

  seq_sampler #(.KEYS(KEYS), .DEPTH(DEPTH), .SLOTS(SLOTS)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_vec  (key_vec),
    .mode     (mode),
    .slot_sel (slot_sel),
    .step     (step),
    .tick     (tick),
    .note     (note),
    .len      (len),
    .full     (full),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++) m_store[s].delete();
    m_ctx  = CTX_LIVE;
    m_slot = 0;
    m_k    = 0;
    m_prev = LIVE;
    m_note = '0;
    m_done = 1'b0;
  endtask

  task automatic model_clock();
    bit chg;
    int n;
    chg    = (mode != m_prev);
    m_done = 1'b0;
    if (mode == LIVE) begin
      m_ctx  = CTX_LIVE;
      m_note = ($countones(key_vec) <= 1) ? key_vec : '0;
    end else if (chg) begin
      m_slot = int'(slot_sel);
      m_note = '0;
      m_k    = 0;
      if (mode == REC) begin
        m_ctx = CTX_REC;
        m_store[m_slot].delete();
      end else begin
        m_ctx = CTX_PLAY;
      end
    end else if (m_ctx == CTX_REC) begin
      m_note = '0;
      if (step && $countones(key_vec) <= 1 && m_store[m_slot].size() < DEPTH)
        m_store[m_slot].push_back(key_vec);
    end else if (m_ctx == CTX_PLAY && tick) begin
      n = m_store[m_slot].size();
      if (mode == LOOP) begin
        m_note = (n == 0) ? '0 : m_store[m_slot][m_k % n];
      end else if (m_k < n) begin
        m_note = m_store[m_slot][m_k];
      end else begin
        m_note = '0;
        m_done = 1'b1;
        m_ctx  = CTX_HALT;
      end
      m_k++;
    end else if (m_ctx == CTX_HALT) begin
      m_note = '0;
    end
    m_prev = mode;
  endtask

  function automatic int exp_len();
    int s;
    s = ((m_ctx == CTX_REC) || (m_ctx == CTX_PLAY)) ? m_slot : int'(slot_sel);
    return m_store[s].size();
  endfunction

  // Drive one cycle's inputs, advance the model, and sample 1 time unit after the edge.
  task automatic cyc(input logic [1:0] m, input logic [SW-1:0] s, input logic [KEYS-1:0] k,
                     input logic st, input logic tk);
    mode     = m;
    slot_sel = s;
    key_vec  = k;
    step     = st;
    tick     = tk;
    model_clock();
    @(posedge clk);
    #1;
  endtask

  logic [KEYS-1:0] seq3 [3];
  logic [KEYS-1:0] exp4 [4];
  logic [1:0]      rmode;
  logic [KEYS-1:0] rkey;
  int              r;

  initial begin
    reset    = 1'b1;
    mode     = LIVE;
    slot_sel = '0;
    key_vec  = '0;
    step     = 1'b0;
    tick     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_note", 32'(note), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_len",  32'(len),  32'(0));
    chk("reset_full", 32'(full), 32'(0));
    reset = 1'b0;

    // LIVE filtering table
    lv[0] = '{key: 5'b00100, exp: 5'b00100};
    lv[1] = '{key: 5'b10100, exp: 5'b00000};
    lv[2] = '{key: 5'b10000, exp: 5'b10000};
    lv[3] = '{key: 5'b00000, exp: 5'b00000};
    lv[4] = '{key: 5'b11111, exp: 5'b00000};
    lv[5] = '{key: 5'b00001, exp: 5'b00001};
    for (int i = 0; i < 6; i++) begin
      cyc(LIVE, 1'b0, lv[i].key, 1'b0, 1'b0);
      chk($sformatf("live_%0d", i), 32'(note), 32'(lv[i].exp));
    end

    // Record slot0 with one invalid step, then one-shot playback
    cyc(REC, 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("rec_entry_note", 32'(note), 32'(0));
    cyc(REC, 1'b0, 5'b10000, 1'b1, 1'b0);
    cyc(REC, 1'b0, 5'b00000, 1'b1, 1'b0);
    cyc(REC, 1'b0, 5'b00001, 1'b1, 1'b0);
    cyc(REC, 1'b0, 5'b11000, 1'b1, 1'b0);
    chk("rec3_len",  32'(len),  32'(3));
    chk("rec3_full", 32'(full), 32'(0));
    chk("rec_note",  32'(note), 32'(0));
    cyc(PLAY, 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("play_entry_note", 32'(note), 32'(0));
    exp4[0] = 5'b10000; exp4[1] = 5'b00000; exp4[2] = 5'b00001; exp4[3] = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      cyc(PLAY, 1'b0, 5'b00000, 1'b0, 1'b1);
      chk($sformatf("play_note_%0d", i), 32'(note), 32'(exp4[i]));
      chk($sformatf("play_done_%0d", i), 32'(done), 32'(i == 3));
    end
    cyc(PLAY, 1'b0, 5'b00000, 1'b0, 1'b1);
    chk("halt_note", 32'(note), 32'(0));
    chk("halt_done", 32'(done), 32'(0));

    // Fill slot1 past DEPTH
    cyc(REC, 1'b1, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(REC, 1'b1, 5'(1 << (i % 5)), 1'b1, 1'b0);
      if (i == 6) chk("fill7_full", 32'(full), 32'(0));
      if (i == 7) begin
        chk("fill8_len",  32'(len),  32'(8));
        chk("fill8_full", 32'(full), 32'(1));
      end
    end
    chk("fill10_len",  32'(len),  32'(8));
    chk("fill10_full", 32'(full), 32'(1));
    cyc(LIVE, 1'b1, 5'b00000, 1'b0, 1'b0);
    chk("live_len_slot1", 32'(len), 32'(8));
    cyc(LIVE, 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("live_len_slot0", 32'(len), 32'(3));

    // Re-record slot1 with 3 steps and loop it
    seq3[0] = 5'b00010; seq3[1] = 5'b00000; seq3[2] = 5'b01000;
    cyc(REC, 1'b1, 5'b00000, 1'b0, 1'b0);
    chk("rerec_clear", 32'(len), 32'(0));
    for (int i = 0; i < 3; i++) cyc(REC, 1'b1, seq3[i], 1'b1, 1'b0);
    cyc(LOOP, 1'b1, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(LOOP, 1'b1, 5'b00000, 1'b0, 1'b1);
      chk($sformatf("loop_note_%0d", i), 32'(note), 32'(seq3[i % 3]));
      chk($sformatf("loop_done_%0d", i), 32'(done), 32'(0));
      cyc(LOOP, 1'b0, 5'b00000, 1'b0, 1'b0);
      chk($sformatf("loop_hold_%0d", i), 32'(note), 32'(seq3[i % 3]));
      chk($sformatf("loop_len_%0d", i),  32'(len),  32'(3));
    end

    // Mode change in the same cycle as a step or a tick
    cyc(REC, 1'b0, 5'b00000, 1'b0, 1'b0);
    cyc(REC, 1'b0, 5'b00100, 1'b1, 1'b0);
    cyc(REC, 1'b0, 5'b01000, 1'b1, 1'b0);
    cyc(PLAY, 1'b0, 5'b10000, 1'b1, 1'b0);
    chk("chg_step_len",  32'(len),  32'(2));
    chk("chg_step_note", 32'(note), 32'(0));
    cyc(PLAY, 1'b0, 5'b00000, 1'b0, 1'b1);
    chk("chg_first_note", 32'(note), 32'(5'b00100));
    cyc(LOOP, 1'b0, 5'b00000, 1'b0, 1'b1);
    chk("chg_tick_note", 32'(note), 32'(0));
    cyc(LOOP, 1'b0, 5'b00000, 1'b0, 1'b1);
    chk("reloop_0", 32'(note), 32'(5'b00100));
    cyc(LOOP, 1'b0, 5'b00000, 1'b0, 1'b1);
    chk("reloop_1", 32'(note), 32'(5'b01000));
    cyc(LOOP, 1'b0, 5'b00000, 1'b0, 1'b1);
    chk("reloop_wrap", 32'(note), 32'(5'b00100));

    // Asynchronous reset during LOOP playback
    cyc(LIVE, 1'b1, 5'b00000, 1'b0, 1'b0);
    cyc(LOOP, 1'b1, 5'b00000, 1'b0, 1'b0);
    cyc(LOOP, 1'b1, 5'b00000, 1'b0, 1'b1);
    chk("pre_rst_note", 32'(note), 32'(5'b00010));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_note", 32'(note), 32'(0));
    model_reset();
    mode = LIVE;
    tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    slot_sel = 1'b0;
    #1;
    chk("post_rst_len0", 32'(len), 32'(0));
    slot_sel = 1'b1;
    #1;
    chk("post_rst_len1",  32'(len),  32'(0));
    chk("post_rst_full1", 32'(full), 32'(0));
    cyc(PLAY, 1'b1, 5'b00000, 1'b0, 1'b0);
    cyc(PLAY, 1'b1, 5'b00000, 1'b0, 1'b1);
    chk("empty_play_done", 32'(done), 32'(1));
    chk("empty_play_note", 32'(note), 32'(0));
    cyc(LOOP, 1'b1, 5'b00000, 1'b0, 1'b0);
    cyc(LOOP, 1'b1, 5'b00000, 1'b0, 1'b1);
    chk("empty_loop_done", 32'(done), 32'(0));
    chk("empty_loop_note", 32'(note), 32'(0));

    // Randomized run against the model
    reset = 1'b1;
    model_reset();
    mode  = LIVE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rmode = LIVE;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 5)      rkey = KEYS'(1) << $urandom_range(0, KEYS - 1);
      else if (r < 7) rkey = '0;
      else            rkey = KEYS'($urandom);
      cyc(rmode, SW'($urandom_range(0, 1)), rkey, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rnd_note", 32'(note), 32'(m_note));
      chk("rnd_done", 32'(done), 32'(m_done));
      chk("rnd_len",  32'(len),  32'(exp_len()));
      chk("rnd_full", 32'(full), 32'(exp_len() == DEPTH));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_sampler.md
SEQ_SAMPLER -- requirements
Module: seq_sampler

Interface
REQ-001 Parameter KEYS, default 5, width of the one-hot key vector and of the note output.
REQ-002 Parameter DEPTH, default 8, maximum number of steps stored per slot; power of two, minimum 2.
REQ-003 Parameter SLOTS, default 2, number of independent sequence slots; minimum 1.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_vec  input  KEYS  current key state, one bit per key.
REQ-007 mode  input  2  operating mode: 00 LIVE, 01 REC, 10 PLAY, 11 LOOP.
REQ-008 slot_sel  input  max(1,$clog2(SLOTS))  slot index for REC, PLAY and LOOP.
REQ-009 step  input  1  single-cycle capture strobe, used in REC only.
REQ-010 tick  input  1  single-cycle playback-rate enable, used in PLAY and LOOP only.
REQ-011 note  output  KEYS  registered note output.
REQ-012 len  output  $clog2(DEPTH)+1  stored step count of the active slot.
REQ-013 full  output  1  active slot holds DEPTH steps.
REQ-014 done  output  1  one-cycle pulse when a one-shot playback completes.

Function
REQ-015 The FSM SHALL have the states S_LIVE, S_REC, S_PLAY and S_HALT; mode is sampled every cycle.
REQ-016 A valid key vector SHALL be all-zero (rest) or one-hot; any other vector is invalid.
REQ-017 S_LIVE: note SHALL equal the previous cycle's key_vec when that vector was valid, else 0 (latency 1).
REQ-018 On entry to S_REC, the selected slot SHALL be latched and its length cleared to 0 in the same edge; note SHALL read 0 while in S_REC.
REQ-019 In S_REC, a step with a valid key_vec and len<DEPTH SHALL write key_vec to mem[slot][len] and increment len; rests count as steps.
REQ-020 A step with an invalid key_vec, or with len==DEPTH, SHALL be ignored; full stays asserted.
REQ-021 On entry to S_PLAY (mode 10 or 11), the slot SHALL be latched, rd_ptr SHALL be set to 0 and note SHALL be set to 0; slot_sel changes SHALL be ignored until the mode changes.
REQ-022 In S_PLAY, each tick SHALL load note<=mem[slot][rd_ptr] and advance rd_ptr; the first note appears on the edge of the first tick.
REQ-023 On a tick when rd_ptr==len: mode 11 SHALL wrap, with note<=mem[slot][0] and rd_ptr<=1; mode 10 SHALL set note<=0, pulse done and go to S_HALT.
REQ-024 Playing an empty slot (len==0): mode 10 SHALL pulse done on the first tick; mode 11 SHALL hold note at 0 with no done.
REQ-025 S_HALT SHALL hold note at 0 until mode leaves 10; a mode change from PLAY to LOOP SHALL re-enter S_PLAY from step 0.
REQ-026 A mode change SHALL take priority over a step or tick in the same cycle; the strobe is dropped.
REQ-027 Any mode change SHALL be acted on in the cycle it is sampled, including mid-record or mid-playback; stored data of the abandoned slot is kept, except that a new REC entry clears its own slot.
REQ-028 len and full SHALL reflect the latched slot in S_REC and S_PLAY, and the slot_sel slot otherwise.
REQ-029 Storage SHALL be a register array of SLOTS*DEPTH*KEYS bits with a single write port and a single read port.

Reset
REQ-030 The reset assertion SHALL force the state to S_LIVE and set note=0, done=0, all slot lengths=0 and all pointers=0; memory contents need not be cleared.
REQ-031 Reset released mid-record or mid-playback SHALL leave the block in S_LIVE with every slot reading empty.

Verification
REQ-032 LIVE: key_vec=00100 -> note=00100 one cycle later; key_vec=10100 -> note=00000.
REQ-033 REC slot0 with steps carrying 10000, 00000, 00001, 11000 -> len=3, with the 11000 step ignored; PLAY with 4 ticks -> note sequence 10000, 00000, 00001, then 00000 with a done pulse on the 4th tick.
REQ-034 REC of 10 valid steps with DEPTH=8 -> len=8 and full=1 after the 8th step; the 9th and 10th steps are ignored.
REQ-035 LOOP on slot1 holding 3 steps, with 7 ticks -> notes s0,s1,s2,s0,s1,s2,s0, with no done pulse.
REQ-036 Mode 01->10 in the same cycle as a step -> step dropped, len unchanged, rd_ptr=0, note=0.
REQ-037 Reset asserted during LOOP playback -> note=0 immediately (asynchronous); after release, len=0 for every slot and PLAY pulses done on the first tick.
